// File: rtl/weight_fifo_loader.sv
// Weight FIFO producer: streams num_tiles*TILE_ROWS rows from the weight SRAM
// into the weight FIFO write port through a 2-entry skid buffer.
module weight_fifo_loader #(
  parameter int LANES     = 32,
  parameter int TILE_ROWS = 32,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [ADDR_W-1:0]    cmd_base_addr_i,
  input  logic [7:0]           cmd_num_tiles_i,
  output logic                 mem_en_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic [LANES*8-1:0]   mem_rdata_i,
  input  logic                 fifo_ready_i,
  output logic                 wr_o,
  output logic [LANES*8-1:0]   wr_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int ROW_W = LANES * 8;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [15:0]       issue_cnt_q, issue_cnt_d;
  logic [15:0]       write_cnt_q, write_cnt_d;
  logic              rd_vld_p1_q, rd_vld_p1_d;
  logic              zero_done_q, zero_done_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ROW_W-1:0]  head_q, head_d;
  logic [ROW_W-1:0]  tail_q, tail_d;

  logic              issue;
  logic              pop;
  logic [15:0]       cmd_rows;
  logic [2:0]        occ;

  assign cmd_rows = 16'(cmd_num_tiles_i) * 16'(TILE_ROWS);
  assign pop      = wr_o && fifo_ready_i;
  // Slots that will be committed after this edge: buffered + in flight - leaving.
  assign occ      = {1'b0, cnt_q} + {2'b00, rd_vld_p1_q} - {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    issue_cnt_d = issue_cnt_q;
    write_cnt_d = write_cnt_q;
    zero_done_d = 1'b0;
    issue       = 1'b0;
    if (pop) begin
      write_cnt_d = write_cnt_q - 16'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d      = cmd_base_addr_i;
          issue_cnt_d = cmd_rows;
          write_cnt_d = cmd_rows;
          if (cmd_num_tiles_i == 8'd0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (issue_cnt_q != 16'd0 && occ < 3'd2) begin
          issue       = 1'b1;
          last_addr_d = addr_q;
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - 16'd1;
          if (issue_cnt_q == 16'd1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (write_cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage p1: SRAM data returns, captured into the skid buffer ----
  always_comb begin
    rd_vld_p1_d = issue;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    case ({rd_vld_p1_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = mem_rdata_i;
        else               tail_d = mem_rdata_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = mem_rdata_i;
        end else begin
          head_d = tail_q;
          tail_d = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      issue_cnt_q <= '0;
      write_cnt_q <= '0;
      rd_vld_p1_q <= 1'b0;
      zero_done_q <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      issue_cnt_q <= issue_cnt_d;
      write_cnt_q <= write_cnt_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      zero_done_q <= zero_done_d;
      cnt_q       <= cnt_d;
    end
  end

  // Row storage carries no reset; wr_data_o is masked by wr_o instead.
  always_ff @(posedge clk_i) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  // ---- stage p2: buffered row presented to the FIFO ----
  assign mem_en_o    = issue;
  assign mem_addr_o  = issue ? addr_q : last_addr_q;
  assign wr_o        = (cnt_q != 2'd0);
  assign wr_data_o   = wr_o ? head_q : '0;
  assign busy_o      = (state_q != S_IDLE);
  assign cmd_ready_o = (state_q == S_IDLE);
  assign done_o      = zero_done_q || (state_q == S_DRAIN && write_cnt_q == 16'd0);

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Directed bench for weight_fifo_loader: timing table, zero-tile command,
// mid-command reset and a random-backpressure scoreboard run.
module tb_weight_fifo_loader;

  localparam int LANES     = 32;
  localparam int TILE_ROWS = 32;
  localparam int ADDR_W    = 16;
  localparam int ROW_W     = LANES * 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [7:0]        cmd_tiles = '0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [ROW_W-1:0]  mem_rdata = '0;
  logic              fifo_ready = 1'b0;
  logic              wr;
  logic [ROW_W-1:0]  wr_data;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  int m_en_first, m_en_last, m_wr_first, m_wr_last, m_done_cyc, m_issued, m_written;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  tiles;
    int          st_lo;
    int          st_hi;
    int          en_first;
    int          en_last;
    int          wr_first;
    int          wr_last;
    int          done_cyc;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  weight_fifo_loader #(
    .LANES(LANES), .TILE_ROWS(TILE_ROWS), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_base_addr_i(cmd_base),
    .cmd_num_tiles_i(cmd_tiles),
    .mem_en_o(mem_en),
    .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata),
    .fifo_ready_i(fifo_ready),
    .wr_o(wr),
    .wr_data_o(wr_data),
    .busy_o(busy),
    .done_o(done)
  );

  // SRAM model: word k holds k[7:0] in every lane, one cycle read latency.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= {LANES{mem_addr[7:0]}};
  end

  // Skid buffer must never receive a capture while full and not popping.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      assert (!(dut.rd_vld_p1_q && dut.cnt_q == 2'd2 && !(wr && fifo_ready)))
      else begin
        bad++;
        $display("FAIL skid_overflow: capture into full buffer at time %0t", $time);
      end
    end
  end

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    total++;
    if (act > lim) begin
      bad++;
      $display("FAIL %s: got %0d expected <= %0d", name, act, lim);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_mem_en"},    mem_en, 1'b0);
    chk({tag, "_mem_addr"},  mem_addr, '0);
    chk({tag, "_wr"},        wr, 1'b0);
    chk({tag, "_wr_data"},   wr_data, '0);
    chk({tag, "_busy"},      busy, 1'b0);
    chk({tag, "_done"},      done, 1'b0);
  endtask

  // Issue one command (accepted at edge 0) and scoreboard it until done_o.
  task automatic run_cmd(input logic [15:0] base, input logic [7:0] tiles,
                         input int st_lo, input int st_hi, input bit rnd);
    logic [15:0]      exp_addr;
    logic [15:0]      exp_row;
    logic [7:0]       b;
    logic [ROW_W-1:0] prev_data;
    bit               prev_stall;
    exp_addr   = base;
    exp_row    = base;
    prev_data  = '0;
    prev_stall = 1'b0;
    m_en_first = -1; m_en_last = -1; m_wr_first = -1; m_wr_last = -1;
    m_done_cyc = -1; m_issued = 0; m_written = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = base; cmd_tiles = tiles; fifo_ready = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    for (int c = 1; c <= 400 && m_done_cyc < 0; c++) begin
      @(negedge clk);
      cmd_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_base   = 16'h5A00;
      cmd_tiles  = 8'd5;
      fifo_ready = rnd ? 1'($urandom_range(0, 1)) : !(c >= st_lo && c <= st_hi);
      #1;
      chk("ready_vs_busy", cmd_ready, !busy);
      chk_le("occupancy", m_issued - m_written, 2);
      if (mem_en) begin
        if (m_en_first < 0) m_en_first = c;
        m_en_last = c;
        chk("rd_addr", mem_addr, exp_addr);
        exp_addr++;
        m_issued++;
      end
      if (wr) begin
        if (m_wr_first < 0) m_wr_first = c;
        m_wr_last = c;
        b = exp_row[7:0];
        chk("wr_data", wr_data, {LANES{b}});
        if (prev_stall) chk("stall_hold", wr_data, prev_data);
        if (fifo_ready) begin
          exp_row++;
          m_written++;
        end
      end else begin
        chk("data_zero_no_wr", wr_data, '0);
      end
      prev_stall = wr && !fifo_ready;
      prev_data  = wr_data;
      if (done) m_done_cyc = c;
    end
    chk("done_seen", (m_done_cyc >= 0), 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0; fifo_ready = 1'b1;
    #1;
    chk("busy_after_done", busy, 1'b0);
    chk("done_single", done, 1'b0);
    chk("cmd_ready_after", cmd_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 8'd1, 0, -1, 1, 32, 3, 34, 35};
    vecs[1] = '{16'h0010, 8'd1, 5, 14, 1, 42, 3, 44, 45};
    vecs[2] = '{16'hFFF0, 8'd1, 0, -1, 1, 32, 3, 34, 35};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("reset");

    for (int i = 0; i < 3; i++) begin
      run_cmd(vecs[i].base, vecs[i].tiles, vecs[i].st_lo, vecs[i].st_hi, 1'b0);
      chk($sformatf("v%0d_en_first", i), m_en_first, vecs[i].en_first);
      chk($sformatf("v%0d_en_last", i),  m_en_last,  vecs[i].en_last);
      chk($sformatf("v%0d_wr_first", i), m_wr_first, vecs[i].wr_first);
      chk($sformatf("v%0d_wr_last", i),  m_wr_last,  vecs[i].wr_last);
      chk($sformatf("v%0d_done_cyc", i), m_done_cyc, vecs[i].done_cyc);
      chk($sformatf("v%0d_issued", i),   m_issued,   32'(vecs[i].tiles) * TILE_ROWS);
      chk($sformatf("v%0d_written", i),  m_written,  32'(vecs[i].tiles) * TILE_ROWS);
    end

    // Empty command: immediate done pulse, no traffic.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 16'h1234; cmd_tiles = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("zero_done", done, 1'b1);
    chk("zero_mem_en", mem_en, 1'b0);
    chk("zero_wr", wr, 1'b0);
    chk("zero_busy", busy, 1'b0);
    @(negedge clk);
    #1;
    chk("zero_done_off", done, 1'b0);
    chk("zero_mem_en2", mem_en, 1'b0);

    // Reset in cycle 10 of a 4-tile load.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 16'h0100; cmd_tiles = 8'd4; fifo_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("abort");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", done, 1'b0);
      chk("abort_no_wr", wr, 1'b0);
      chk("abort_no_mem_en", mem_en, 1'b0);
    end
    run_cmd(16'h0200, 8'd1, 0, -1, 1'b0);
    chk("post_abort_done_cyc", m_done_cyc, 35);
    chk("post_abort_written", m_written, 32);

    // Random backpressure with stray commands while busy.
    run_cmd(16'h0300, 8'd3, 0, -1, 1'b1);
    chk("rand_issued", m_issued, 96);
    chk("rand_written", m_written, 96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
